// File: rtl/elastic_pipe.sv
`default_nettype none
// ============================================================================
// Module   : elastic_pipe
// Brief    : Multi-stage valid/ready pipeline register with bubble collapsing,
//            flush, occupancy count and zero-detect on the output beat.
// Revision : 1.0 - initial release
// ============================================================================
module elastic_pipe #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [CW-1:0]    occupancy
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [DEPTH-1:0] w_rdy;
    logic [CW-1:0]    w_occ;

    // A stage may load when any stage at or after it is empty, or the sink
    // drains; expressed flat so the ready chain has no combinational feedback.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
        assign w_rdy[i] = out_ready | ~(&v_q[DEPTH-1:i]);
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (w_rdy[0]) begin
            v_d[0] = in_valid & ~flush;
            d_d[0] = in_data;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (w_rdy[i]) begin
                v_d[i] = v_q[i-1];
                d_d[i] = d_q[i-1];
            end
        end
        if (flush) begin
            v_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + CW'(v_q[i]);
        end
    end

    assign in_ready  = w_rdy[0] & ~flush;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign out_zero  = v_q[DEPTH-1] & (d_q[DEPTH-1] == '0);
    assign occupancy = w_occ;

endmodule
`default_nettype wire

// File: tb/tb_elastic_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_elastic_pipe
// Brief    : Self-checking bench for elastic_pipe at DEPTH 2 (directed) and
//            DEPTH 1/4 (random, queue-based scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_elastic_pipe;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        iv   [3];
    logic        ir   [3];
    logic [15:0] id   [3];
    logic        ov   [3];
    logic        ordy [3];
    logic [15:0] od   [3];
    logic        oz   [3];
    logic [2:0]  occ  [3];
    logic [1:0]  occ_p2;
    logic [0:0]  occ_p1;
    logic [2:0]  occ_p4;

    int DEP [3] = '{2, 1, 4};
    int n_cmp  = 0;
    int n_fail = 0;
    logic [15:0] mq [3][$];

    assign occ[0] = {1'b0, occ_p2};
    assign occ[1] = {2'b00, occ_p1};
    assign occ[2] = occ_p4;

    elastic_pipe #(.WIDTH(16), .DEPTH(2)) u_d2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .out_zero(oz[0]), .occupancy(occ_p2));

    elastic_pipe #(.WIDTH(16), .DEPTH(1)) u_d1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .out_zero(oz[1]), .occupancy(occ_p1));

    elastic_pipe #(.WIDTH(16), .DEPTH(4)) u_d4 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
        .out_zero(oz[2]), .occupancy(occ_p4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            iv[k]   = 1'b0;
            id[k]   = 16'h0;
            ordy[k] = 1'b0;
        end
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b1; id[k] = 16'hFFFF; ordy[k] = 1'b0;
        end
        next_cycle();
        next_cycle();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) iv[k] = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (ov[k] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, ov[k]); end
            n_cmp++;
            if (od[k] !== 16'h0) begin n_fail++; $display("FAIL reset_out_data[%0d]: got %h want 0000", k, od[k]); end
            n_cmp++;
            if (oz[k] !== 1'b0) begin n_fail++; $display("FAIL reset_out_zero[%0d]: got %b want 0", k, oz[k]); end
            n_cmp++;
            if (occ[k] !== 3'd0) begin n_fail++; $display("FAIL reset_occupancy[%0d]: got %0d want 0", k, occ[k]); end
            n_cmp++;
            if (ir[k] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, ir[k]); end
        end
        next_cycle();
    endtask

    // Beat n is accepted at edge n; with DEPTH=2 it is visible during cycle n+2.
    task automatic test_stream();
        int acc, em;
        idle_all();
        ordy[0] = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            iv[0] = (j <= 5);
            id[0] = (j <= 5) ? 16'(j) : 16'h0;
            #1;
            acc = (j - 1 < 5) ? j - 1 : 5;
            em  = (j - 3 < 0) ? 0 : ((j - 3 > 5) ? 5 : j - 3);
            n_cmp++;
            if (ov[0] !== (j >= 3 && j <= 7)) begin n_fail++; $display("FAIL stream_out_valid cyc%0d: got %b want %b", j, ov[0], (j >= 3 && j <= 7)); end
            if (j >= 3 && j <= 7) begin
                n_cmp++;
                if (od[0] !== 16'(j - 2)) begin n_fail++; $display("FAIL stream_out_data cyc%0d: got %h want %h", j, od[0], 16'(j - 2)); end
            end
            n_cmp++;
            if (occ[0] !== 3'(acc - em)) begin n_fail++; $display("FAIL stream_occupancy cyc%0d: got %0d want %0d", j, occ[0], acc - em); end
            n_cmp++;
            if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready cyc%0d: got %b want 1", j, ir[0]); end
            next_cycle();
        end
    endtask

    task automatic test_back_pressure();
        logic [15:0] vals [3];
        logic        exp_ir [8];
        logic [15:0] exp_od [8];
        vals = '{16'hA, 16'hB, 16'hC};
        exp_ir = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_od = '{16'h0, 16'h0, 16'hA, 16'hA, 16'hA, 16'hB, 16'hC, 16'h0};
        idle_all();
        for (int j = 1; j <= 8; j++) begin
            iv[0]   = (j <= 5);
            id[0]   = (j <= 3) ? vals[j-1] : 16'hC;
            ordy[0] = (j >= 5);
            #1;
            n_cmp++;
            if (ir[0] !== exp_ir[j-1]) begin n_fail++; $display("FAIL bp_in_ready cyc%0d: got %b want %b", j, ir[0], exp_ir[j-1]); end
            n_cmp++;
            if (ov[0] !== (j >= 3 && j <= 7)) begin n_fail++; $display("FAIL bp_out_valid cyc%0d: got %b want %b", j, ov[0], (j >= 3 && j <= 7)); end
            if (j >= 3 && j <= 7) begin
                n_cmp++;
                if (od[0] !== exp_od[j-1]) begin n_fail++; $display("FAIL bp_out_data cyc%0d: got %h want %h", j, od[0], exp_od[j-1]); end
            end
            if (j == 3 || j == 4) begin
                n_cmp++;
                if (occ[0] !== 3'd2) begin n_fail++; $display("FAIL bp_occupancy cyc%0d: got %0d want 2", j, occ[0]); end
            end
            next_cycle();
        end
    endtask

    task automatic test_zero_flag();
        idle_all();
        ordy[0] = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            iv[0] = (j <= 2);
            id[0] = (j == 2) ? 16'h0010 : 16'h0000;
            #1;
            n_cmp++;
            if (oz[0] !== (j == 3)) begin n_fail++; $display("FAIL zero_flag cyc%0d: got %b want %b", j, oz[0], (j == 3)); end
            n_cmp++;
            if (ov[0] !== (j == 3 || j == 4)) begin n_fail++; $display("FAIL zero_out_valid cyc%0d: got %b want %b", j, ov[0], (j == 3 || j == 4)); end
            if (j == 4) begin
                n_cmp++;
                if (od[0] !== 16'h0010) begin n_fail++; $display("FAIL zero_out_data cyc%0d: got %h want 0010", j, od[0]); end
            end
            next_cycle();
        end
    endtask

    task automatic test_flush();
        idle_all();
        for (int j = 1; j <= 7; j++) begin
            flush   = (j == 3);
            iv[0]   = (j <= 4);
            id[0]   = (j == 1) ? 16'h0011 : (j == 2) ? 16'h0022 : (j == 3) ? 16'h0033 : 16'h0042;
            ordy[0] = (j >= 3);
            #1;
            if (j == 3) begin
                n_cmp++;
                if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", ir[0]); end
                n_cmp++;
                if (occ[0] !== 3'd2) begin n_fail++; $display("FAIL flush_pre_occupancy: got %0d want 2", occ[0]); end
            end
            if (j == 4) begin
                n_cmp++;
                if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", ov[0]); end
                n_cmp++;
                if (occ[0] !== 3'd0) begin n_fail++; $display("FAIL flush_occupancy: got %0d want 0", occ[0]); end
                n_cmp++;
                if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL flush_resume_in_ready: got %b want 1", ir[0]); end
            end
            if (j == 6) begin
                n_cmp++;
                if (ov[0] !== 1'b1 || od[0] !== 16'h0042) begin n_fail++; $display("FAIL flush_after_beat: got v=%b d=%h want v=1 d=0042", ov[0], od[0]); end
            end
            if (j == 7) begin
                n_cmp++;
                if (ov[0] !== 1'b0 || occ[0] !== 3'd0) begin n_fail++; $display("FAIL flush_drained: got v=%b occ=%0d want v=0 occ=0", ov[0], occ[0]); end
            end
            next_cycle();
        end
    endtask

    // Scoreboard: each queue holds beats accepted but not yet emitted, so its
    // size is the expected occupancy and its head the expected output beat.
    task automatic test_random();
        logic exp_ir;
        idle_all();
        for (int k = 0; k < 3; k++) mq[k].delete();
        for (int c = 0; c < 10000; c++) begin
            flush = (c < 9980) && ($urandom_range(0, 199) == 0);
            for (int k = 0; k < 3; k++) begin
                iv[k]   = (c < 9980) && ($urandom_range(0, 9) < 6);
                id[k]   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
                ordy[k] = (c >= 9980) || ($urandom_range(0, 9) < 5);
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                exp_ir = ((mq[k].size() < DEP[k]) || ordy[k]) && !flush;
                n_cmp++;
                if (ir[k] !== exp_ir) begin n_fail++; $display("FAIL rand_in_ready[%0d] cyc%0d: got %b want %b", k, c, ir[k], exp_ir); end
                n_cmp++;
                if (occ[k] !== 3'(mq[k].size())) begin n_fail++; $display("FAIL rand_occupancy[%0d] cyc%0d: got %0d want %0d", k, c, occ[k], mq[k].size()); end
                n_cmp++;
                if (oz[k] !== (ov[k] === 1'b1 && od[k] === 16'h0)) begin n_fail++; $display("FAIL rand_out_zero[%0d] cyc%0d: got %b", k, c, oz[k]); end
                if (ov[k] === 1'b1) begin
                    n_cmp++;
                    if (mq[k].size() == 0) begin
                        n_fail++; $display("FAIL rand_spurious_beat[%0d] cyc%0d: got %h want none", k, c, od[k]);
                    end else if (od[k] !== mq[k][0]) begin
                        n_fail++; $display("FAIL rand_out_data[%0d] cyc%0d: got %h want %h", k, c, od[k], mq[k][0]);
                    end
                end
                if (flush) begin
                    mq[k].delete();
                end else begin
                    if (ov[k] === 1'b1 && ordy[k] && mq[k].size() > 0) void'(mq[k].pop_front());
                    if (iv[k] && exp_ir) mq[k].push_back(id[k]);
                end
            end
            next_cycle();
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (mq[k].size() != 0 || ov[k] !== 1'b0) begin n_fail++; $display("FAIL rand_lossless[%0d]: got %0d undelivered, v=%b want 0", k, mq[k].size(), ov[k]); end
        end
        idle_all();
    endtask

    initial begin
        idle_all();
        reset = 1'b0;
        test_reset();
        test_stream();
        test_back_pressure();
        test_zero_flag();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
